// File: rtl/mux_nx1_scan_if.sv
// mux_nx1_scan_if: signal bundle for the registered N-to-1 scanning mux.
//   din        packed channels, channel k = din[k*WIDTH +: WIDTH]
//   sel        manual channel select
//   mode       0 = manual, 1 = auto-scan
//   hold       freezes auto-scan (ignored in manual mode)
//   dout       registered selected channel data
//   cur_sel    channel currently applied to dout
//   dout_valid dout holds meaningful data (set after reset release)
//   sel_err    one-cycle pulse: manual select out of range
//   scan_wrap  one-cycle pulse: auto-scan wrapped back to channel 0
// master drives the select/data inputs; slave is the mux itself.
interface mux_nx1_scan_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic                      hold;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          cur_sel;
  logic                      dout_valid;
  logic                      sel_err;
  logic                      scan_wrap;

  modport master (
    output din, sel, mode, hold,
    input  dout, cur_sel, dout_valid, sel_err, scan_wrap
  );

  modport slave (
    input  din, sel, mode, hold,
    output dout, cur_sel, dout_valid, sel_err, scan_wrap
  );
endinterface

// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: registered N-to-1 channel multiplexer with manual and
// auto-scan selection.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mux_nx1_scan_if.slave (din/sel/mode/hold in; dout/cur_sel/
//          dout_valid/sel_err/scan_wrap out)
// dout and cur_sel are loaded from the same next_sel on the same edge, so
// the two always refer to the same channel. Status pulses are registered
// alongside them and describe the transition that just happened.
module mux_nx1_scan #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned DWELL    = 16,
  parameter int unsigned SEL_W    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_nx1_scan_if.slave  bus
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] cur_sel_q, next_sel;
  logic [CNT_W-1:0] cnt_q, next_cnt;
  logic [WIDTH-1:0] dout_q, next_dout;
  logic             valid_q;
  logic             err_q, next_err;
  logic             wrap_q, next_wrap;

  // Select / counter next-state
  always_comb begin
    next_sel  = cur_sel_q;
    next_cnt  = '0;
    next_err  = 1'b0;
    next_wrap = 1'b0;
    if (!bus.mode) begin
      if (32'(bus.sel) < CHANNELS) begin
        next_sel = bus.sel;
      end else begin
        next_err = 1'b1;
      end
    end else if (bus.hold) begin
      next_cnt = cnt_q;
    end else if (cnt_q != CNT_LAST) begin
      next_cnt = cnt_q + 1'b1;
    end else if (cur_sel_q == SEL_LAST) begin
      // Wrap at CHANNELS-1, not at the select field's natural rollover
      next_sel  = '0;
      next_wrap = 1'b1;
    end else begin
      next_sel = cur_sel_q + 1'b1;
    end
  end

  // Data select: explicit compare per channel keeps out-of-range indices
  // from producing X; next_sel is always in range anyway.
  always_comb begin
    next_dout = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(next_sel) == k) begin
        next_dout = bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_sel_q <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      cur_sel_q <= next_sel;
      cnt_q     <= next_cnt;
      dout_q    <= next_dout;
      valid_q   <= 1'b1;
      err_q     <= next_err;
      wrap_q    <= next_wrap;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.cur_sel    = cur_sel_q;
  assign bus.dout_valid = valid_q;
  assign bus.sel_err    = err_q;
  assign bus.scan_wrap  = wrap_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
module tb_mux_nx1_scan;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-channel instance for reset/manual sweep
  mux_nx1_scan_if #(.CHANNELS(4), .WIDTH(1), .SEL_W(2)) if4 ();
  // 3-channel instance for out-of-range, auto-scan, hold, mode switching
  mux_nx1_scan_if #(.CHANNELS(3), .WIDTH(1), .SEL_W(2)) if3 ();

  mux_nx1_scan #(.CHANNELS(4), .WIDTH(1), .DWELL(16), .SEL_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave)
  );
  mux_nx1_scan #(.CHANNELS(3), .WIDTH(1), .DWELL(4), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave)
  );

  typedef struct {
    int         id;
    string      name;
    logic       dout;
    logic [1:0] cur;
    logic       valid;
    logic       err;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Monitor: outputs are registered every cycle, so one expectation is
  // consumed per falling edge.
  initial begin
    exp_t e;
    logic       a_dout, a_valid, a_err, a_wrap;
    logic [1:0] a_cur;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.id == 0) begin
          a_dout = if4.dout; a_cur = if4.cur_sel; a_valid = if4.dout_valid;
          a_err = if4.sel_err; a_wrap = if4.scan_wrap;
        end else begin
          a_dout = if3.dout; a_cur = if3.cur_sel; a_valid = if3.dout_valid;
          a_err = if3.sel_err; a_wrap = if3.scan_wrap;
        end
        checks++;
        if (a_dout !== e.dout || a_cur !== e.cur || a_valid !== e.valid ||
            a_err !== e.err || a_wrap !== e.wrap) begin
          errors++;
          $display("FAIL %s: got dout=%b cur_sel=%0d valid=%b err=%b wrap=%b, want dout=%b cur_sel=%0d valid=%b err=%b wrap=%b",
                   e.name, a_dout, a_cur, a_valid, a_err, a_wrap,
                   e.dout, e.cur, e.valid, e.err, e.wrap);
        end
      end
    end
  end

  // Inputs are set before calling; the expectation describes the state
  // after the next rising edge.
  task automatic cyc(input int id, input string nm, input logic d,
                     input logic [1:0] c, input logic v, input logic er,
                     input logic w);
    exp_t e;
    @(posedge clk);
    e.id = id; e.name = nm; e.dout = d; e.cur = c;
    e.valid = v; e.err = er; e.wrap = w;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drv3(input logic m, input logic h, input logic [1:0] s,
                      input logic [2:0] d);
    if3.mode = m; if3.hold = h; if3.sel = s; if3.din = d;
  endtask

  initial begin
    logic [3:0] dv;
    rst_n = 1'b0;
    if4.din = 4'hF; if4.sel = 2'd3; if4.mode = 1'b0; if4.hold = 1'b0;
    drv3(1'b0, 1'b0, 2'd0, 3'b000);
    @(negedge clk);

    // Reset with active-looking inputs
    for (int i = 0; i < 3; i++) cyc(0, "reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(0, "reset_release", 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);

    // Manual sweep on the 4-channel instance
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 16; d++) begin
        dv = 4'(d);
        if4.sel = 2'(s); if4.din = dv;
        for (int r = 0; r < 5; r++) cyc(0, "manual_sweep", dv[s], 2'(s), 1'b1, 1'b0, 1'b0);
      end
    end

    // Out-of-range select on the 3-channel instance
    drv3(1'b0, 1'b0, 2'd1, 3'b010); cyc(1, "oor_sel1", 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    drv3(1'b0, 1'b0, 2'd3, 3'b010); cyc(1, "oor_bad1", 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    drv3(1'b0, 1'b0, 2'd3, 3'b000); cyc(1, "oor_bad2", 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    drv3(1'b0, 1'b0, 2'd1, 3'b010); cyc(1, "oor_clear", 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    drv3(1'b0, 1'b0, 2'd0, 3'b101); cyc(1, "pre_auto", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);

    // Auto-scan, DWELL=4, din=101 (ch0=1 ch1=0 ch2=1); sel=3 must be ignored
    drv3(1'b1, 1'b0, 2'd3, 3'b101);
    for (int i = 0; i < 3; i++) cyc(1, "auto_ch0", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1, "auto_ch1", 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1, "auto_ch2", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    cyc(1, "auto_wrap", 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    cyc(1, "auto_cnt1", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1, "auto_cnt2", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);

    // Hold at counter=2; dout keeps re-sampling channel 0
    drv3(1'b1, 1'b1, 2'd3, 3'b100);
    for (int i = 0; i < 5; i++) cyc(1, "hold", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    drv3(1'b1, 1'b0, 2'd3, 3'b101);
    cyc(1, "hold_rel_cnt3", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1, "hold_rel_adv", 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, "post_hold_ch1", 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc(1, "post_hold_ch2", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);

    // Auto -> manual -> auto
    drv3(1'b0, 1'b0, 2'd1, 3'b101); cyc(1, "to_manual", 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    drv3(1'b1, 1'b0, 2'd1, 3'b101);
    for (int i = 0; i < 3; i++) cyc(1, "reauto_dwell", 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc(1, "reauto_adv", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    cyc(1, "reauto_cnt1", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);

    // Mid-dwell reset with hold asserted
    rst_n = 1'b0; drv3(1'b1, 1'b1, 2'd2, 3'b101);
    cyc(1, "mid_reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; drv3(1'b0, 1'b0, 2'd2, 3'b101);
    cyc(1, "mid_reset_rel", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);

    // Wrap coinciding with switch to manual: manual wins, no pulse
    drv3(1'b1, 1'b0, 2'd2, 3'b101);
    for (int i = 0; i < 3; i++) cyc(1, "prewrap_dwell", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    drv3(1'b0, 1'b0, 2'd2, 3'b101);
    cyc(1, "wrap_vs_manual", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    // Counter must have been cleared: full DWELL before the wrap
    drv3(1'b1, 1'b0, 2'd2, 3'b101);
    for (int i = 0; i < 3; i++) cyc(1, "cleared_dwell", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    cyc(1, "cleared_wrap", 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && q.size() == 0) && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    if (budget >= 20000) begin
      errors++;
      $display("FAIL timeout: got %0d pending expectations, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised, registered N-to-1 channel multiplexer; successor to the combinational 4x1 mux.
- Selects one WIDTH-bit channel from a packed input bus.
- Manual mode: external select. Auto-scan mode: internal rotation through channels, holding each for DWELL cycles.
- Feeds channel-scanning and test-pattern paths; output, applied select and status flags are all registered and mutually coherent.

Parameters:
- CHANNELS, 4, number of input channels (2..64).
- WIDTH, 1, bits per channel.
- DWELL, 16, cycles each channel is held in auto-scan mode (1..65535).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- din  input  CHANNELS*WIDTH  packed channels; channel k = din[k*WIDTH +: WIDTH].
- sel  input  SEL_W  manual channel select.
- mode  input  1  0 = manual, 1 = auto-scan.
- hold  input  1  freezes auto-scan counter and select. Ignored in manual mode.
- dout  output  WIDTH  registered selected channel data.
- cur_sel  output  SEL_W  channel applied to dout.
- dout_valid  output  1  dout holds meaningful data.
- sel_err  output  1  one-cycle pulse: manual sel out of range.
- scan_wrap  output  1  one-cycle pulse: auto-scan wrapped CHANNELS-1 -> 0.

Behaviour:
- Reset (rst_n low at rising clk): dout=0, cur_sel=0, dwell counter=0, dout_valid=0, sel_err=0, scan_wrap=0.
- Reset overrides all other inputs, including mid-dwell and while hold is high.
- Every cycle, compute next_sel.
- Register on the same edge: cur_sel <= next_sel, and dout <= channel next_sel of the din sampled at that edge.
- Latency: din or sel change to dout = 1 cycle.
- dout and cur_sel always refer to the same channel.
- dout_valid goes to 1 on the first rising edge with rst_n high, then stays 1 until the next reset.
- Manual mode (mode=0):
  - sel < CHANNELS: next_sel = sel.
  - sel >= CHANNELS: next_sel = cur_sel (retained), and sel_err=1 for that cycle. Pulses repeat each cycle the bad select persists.
  - Dwell counter is held at 0.
- Auto mode (mode=1), dwell counter runs 0..DWELL-1:
  - hold=1: counter and cur_sel frozen; dout still re-samples din of cur_sel every cycle.
  - hold=0 and counter < DWELL-1: counter increments; next_sel = cur_sel.
  - hold=0 and counter = DWELL-1: counter returns to 0 and next_sel = cur_sel+1.
  - Wrap: if cur_sel = CHANNELS-1, next_sel = 0 and scan_wrap=1 for that cycle. CHANNELS need not be a power of two; wrap is at CHANNELS-1, never at 2**SEL_W-1.
  - DWELL=1: select advances every cycle.
  - sel and sel_err are ignored; sel_err=0.
- Mode switch manual -> auto: counter starts at 0 from the current cur_sel. The first advance occurs DWELL cycles after the first auto-mode edge.
- Mode switch auto -> manual: sel takes effect at the first manual-mode edge; counter cleared to 0.
- Simultaneous wrap and mode change to manual: manual wins; no scan_wrap pulse.
- Arithmetic: counter width = clog2(DWELL) (minimum 1); select increment is modulo CHANNELS; no X propagation on out-of-range indices.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with din=4'hF, sel=3 -> dout=0, cur_sel=0, dout_valid=0. Release rst_n -> dout_valid=1 after 1 edge.
- Manual sweep, CHANNELS=4, WIDTH=1:
  - For each sel 0..3, increment din 0..15 every 5 cycles.
  - Required: dout = din[sel] one cycle later for all 64 combinations; sel_err stays 0.
- Out-of-range, CHANNELS=3, SEL_W=2:
  - Apply sel=1, then sel=3 for 2 cycles.
  - Required: cur_sel stays 1, dout follows din[1], sel_err high exactly 2 cycles.
- Auto-scan, CHANNELS=3, DWELL=4, din=3'b101:
  - cur_sel sequence 0,0,0,0,1,1,1,1,2,2,2,2,0.
  - dout sequence 1,1,1,1,0,0,0,0,1,...
  - scan_wrap pulses on the 2->0 transition only.
- Hold: in auto mode at counter=2, assert hold 5 cycles -> cur_sel unchanged. After release, advance occurs 1 cycle later (counter resumes at 2->3).
- Mode switch and mid-scan reset:
  - Auto at cur_sel=2, switch to manual with sel=1 -> cur_sel=1 next edge.
  - Switch back to auto -> first advance after DWELL cycles.
  - Pulse rst_n low mid-dwell -> all outputs return to reset values on that edge.
